// File: rtl/tm_sch_pri_sel.sv
// Strict-priority level selector: walks the active-level bitmap from level 0 upward,
// reading one priority control memory at a time until a non-NULL head is found.
// Optional ack timeout is enabled by defining TM_SCH_PRI_SEL_TIMEOUT_EN.
module tm_sch_pri_sel #(
    parameter int QID_NBITS   = 8,
    parameter int DEPTH_NBITS = 8,
    parameter int TO_NBITS    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_req_valid,
    output logic                     sel_req_ready,
    input  logic [DEPTH_NBITS-1:0]   sel_req_sch_id,
    input  logic [7:0]               sel_req_pri_bmap,
    output logic [7:0]               pri_sch_ctrl_rd,
    output logic [DEPTH_NBITS-1:0]   pri_sch_ctrl_raddr,
    input  logic [7:0]               pri_sch_ctrl_ack,
    input  logic [8*2*QID_NBITS-1:0] pri_sch_ctrl_rdata,
    output logic                     sel_rsp_valid,
    input  logic                     sel_rsp_ready,
    output logic [2:0]               sel_rsp_pri,
    output logic [QID_NBITS-1:0]     sel_rsp_qid,
    output logic                     sel_rsp_empty,
    output logic                     sel_rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RSP
    } state_t;

    state_t                   state, state_nxt;
    logic [DEPTH_NBITS-1:0]   raddr_q, raddr_nxt;
    logic [7:0]               mask_q, mask_nxt;
    logic [2:0]               lvl_q, lvl_nxt;
    logic [2:0]               pri_q, pri_nxt;
    logic [QID_NBITS-1:0]     qid_q, qid_nxt;
    logic                     empty_q, empty_nxt;
    logic [2:0]               issue_lvl;
    logic [7:0]               mask_cleared;
    logic [QID_NBITS-1:0]     head [8];
    logic [8*QID_NBITS-1:0]   tails_unused;

`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
    logic [TO_NBITS-1:0]      to_cnt_q, to_cnt_nxt;
    logic                     err_q, err_nxt;
`else
    localparam int unused_to_nbits = TO_NBITS;
`endif

    // Only the head half of each control word matters for selection.
    for (genvar n = 0; n < 8; n++) begin : g_split
        assign head[n] = pri_sch_ctrl_rdata[n*2*QID_NBITS+QID_NBITS +: QID_NBITS];
        assign tails_unused[n*QID_NBITS +: QID_NBITS] = pri_sch_ctrl_rdata[n*2*QID_NBITS +: QID_NBITS];
    end

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

    assign issue_lvl    = lowest_set(mask_q);
    assign mask_cleared = mask_q & ~(8'd1 << lvl_q);

    assign sel_req_ready      = (state == IDLE);
    assign sel_rsp_valid      = (state == RSP);
    assign pri_sch_ctrl_rd    = (state == ISSUE) ? (8'd1 << issue_lvl) : 8'd0;
    assign pri_sch_ctrl_raddr = raddr_q;
    assign sel_rsp_pri        = pri_q;
    assign sel_rsp_qid        = qid_q;
    assign sel_rsp_empty      = empty_q;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
    assign sel_rsp_err        = err_q;
`else
    assign sel_rsp_err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        raddr_nxt = raddr_q;
        mask_nxt  = mask_q;
        lvl_nxt   = lvl_q;
        pri_nxt   = pri_q;
        qid_nxt   = qid_q;
        empty_nxt = empty_q;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
        to_cnt_nxt = to_cnt_q;
        err_nxt    = err_q;
`endif
        case (state)
            IDLE: begin
                if (sel_req_valid) begin
                    raddr_nxt = sel_req_sch_id;
                    mask_nxt  = sel_req_pri_bmap;
                    if (sel_req_pri_bmap == 8'd0) begin
                        state_nxt = RSP;
                        pri_nxt   = 3'd0;
                        qid_nxt   = '0;
                        empty_nxt = 1'b1;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
                        err_nxt   = 1'b0;
`endif
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lvl_nxt   = issue_lvl;
                state_nxt = WAIT;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
                to_cnt_nxt = '0;
`endif
            end
            WAIT: begin
                // Acks from levels other than the one just read are stale or spurious.
                if (pri_sch_ctrl_ack[lvl_q]) begin
                    if (head[lvl_q] != '1) begin
                        state_nxt = RSP;
                        pri_nxt   = lvl_q;
                        qid_nxt   = head[lvl_q];
                        empty_nxt = 1'b0;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
                        err_nxt   = 1'b0;
`endif
                    end else begin
                        mask_nxt = mask_cleared;
                        if (mask_cleared == 8'd0) begin
                            state_nxt = RSP;
                            pri_nxt   = 3'd0;
                            qid_nxt   = '0;
                            empty_nxt = 1'b1;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
                            err_nxt   = 1'b0;
`endif
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
                else if (to_cnt_q == '1) begin
                    state_nxt = RSP;
                    pri_nxt   = lvl_q;
                    qid_nxt   = '0;
                    empty_nxt = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt_q + {{(TO_NBITS-1){1'b0}}, 1'b1};
                end
`endif
            end
            RSP: begin
                if (sel_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            raddr_q <= '0;
            mask_q  <= '0;
            lvl_q   <= '0;
            pri_q   <= '0;
            qid_q   <= '0;
            empty_q <= 1'b0;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            raddr_q <= raddr_nxt;
            mask_q  <= mask_nxt;
            lvl_q   <= lvl_nxt;
            pri_q   <= pri_nxt;
            qid_q   <= qid_nxt;
            empty_q <= empty_nxt;
`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
            to_cnt_q <= to_cnt_nxt;
            err_q    <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_tm_sch_pri_sel.sv
// Randomized bench for tm_sch_pri_sel: a behavioural memory responder plus a
// strict-priority reference model predicting result, read order and latency.
module tb_tm_sch_pri_sel;

    localparam int Q = 8;
    localparam int D = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               sel_req_valid;
    logic               sel_req_ready;
    logic [D-1:0]       sel_req_sch_id;
    logic [7:0]         sel_req_pri_bmap;
    logic [7:0]         pri_sch_ctrl_rd;
    logic [D-1:0]       pri_sch_ctrl_raddr;
    logic [7:0]         pri_sch_ctrl_ack;
    logic [8*2*Q-1:0]   pri_sch_ctrl_rdata;
    logic               sel_rsp_valid;
    logic               sel_rsp_ready;
    logic [2:0]         sel_rsp_pri;
    logic [Q-1:0]       sel_rsp_qid;
    logic               sel_rsp_empty;
    logic               sel_rsp_err;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [Q-1:0] mem_head [8][256];
    logic [7:0]   spur_ack = 8'd0;
    int           mem_lat = 1;
    bit           withhold = 1'b0;
    logic [D-1:0] cur_sch = '0;
    int           rd_log[$];
    bit           pending = 1'b0;
    int           countdown = 0;
    int           plvl = 0;

    tm_sch_pri_sel #(.QID_NBITS(Q), .DEPTH_NBITS(D), .TO_NBITS(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .sel_req_valid      (sel_req_valid),
        .sel_req_ready      (sel_req_ready),
        .sel_req_sch_id     (sel_req_sch_id),
        .sel_req_pri_bmap   (sel_req_pri_bmap),
        .pri_sch_ctrl_rd    (pri_sch_ctrl_rd),
        .pri_sch_ctrl_raddr (pri_sch_ctrl_raddr),
        .pri_sch_ctrl_ack   (pri_sch_ctrl_ack),
        .pri_sch_ctrl_rdata (pri_sch_ctrl_rdata),
        .sel_rsp_valid      (sel_rsp_valid),
        .sel_rsp_ready      (sel_rsp_ready),
        .sel_rsp_pri        (sel_rsp_pri),
        .sel_rsp_qid        (sel_rsp_qid),
        .sel_rsp_empty      (sel_rsp_empty),
        .sel_rsp_err        (sel_rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory model: ack arrives mem_lat cycles after the read strobe.
    initial begin : responder
        logic [7:0] ack_v;
        pri_sch_ctrl_ack   = 8'd0;
        pri_sch_ctrl_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            ack_v = spur_ack;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                countdown--;
                if (countdown <= 0) begin
                    pending = 1'b0;
                    if (!withhold) ack_v[plvl] = 1'b1;
                end
            end
            for (int n = 0; n < 8; n++) begin
                pri_sch_ctrl_rdata[n*2*Q +: 2*Q] = {mem_head[n][pri_sch_ctrl_raddr], 8'($urandom)};
            end
            pri_sch_ctrl_ack = ack_v;
            if (pri_sch_ctrl_rd != 8'd0) begin
                checkOutput("rd_onehot", $countones(pri_sch_ctrl_rd), 1);
                checkOutput("rd_raddr", pri_sch_ctrl_raddr, cur_sch);
                for (int n = 0; n < 8; n++) begin
                    if (pri_sch_ctrl_rd[n]) plvl = n;
                end
                rd_log.push_back(plvl);
                pending   = 1'b1;
                countdown = mem_lat;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, sel_req_ready, 1);
        checkOutput({tag, "_rd"}, pri_sch_ctrl_rd, 0);
        checkOutput({tag, "_raddr"}, pri_sch_ctrl_raddr, 0);
        checkOutput({tag, "_rsp"}, {sel_rsp_valid, sel_rsp_pri, sel_rsp_qid, sel_rsp_empty, sel_rsp_err}, 0);
    endtask

    // Issue one request, predict its outcome from the stored memory contents and check it.
    task automatic applyStimulus(input logic [D-1:0] sch, input logic [7:0] bm, input int lat, input int hold);
        int  exp_pri, exp_qid, exp_empty, n_chk;
        int  exp_lvls[$];
        int  c0;
        bit  got, stable;
        exp_empty = 1;
        exp_pri   = 0;
        exp_qid   = 0;
        for (int i = 0; i < 8; i++) begin
            if (bm[i]) begin
                exp_lvls.push_back(i);
                if (mem_head[i][sch] != {Q{1'b1}}) begin
                    exp_empty = 0;
                    exp_pri   = i;
                    exp_qid   = int'(mem_head[i][sch]);
                    break;
                end
            end
        end
        mem_lat = lat;
        cur_sch = sch;
        rd_log.delete();
        @(negedge clk);
        sel_req_valid    = 1'b1;
        sel_req_sch_id   = sch;
        sel_req_pri_bmap = bm;
        checkOutput("req_ready", sel_req_ready, 1);
        @(posedge clk);
        #1;
        sel_req_valid = 1'b0;
        c0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            if (sel_rsp_valid) got = 1'b1;
        end
        checkOutput("rsp_seen", got, 1);
        if (got) begin
            checkOutput("rsp_latency", cyc - c0, exp_lvls.size() * (1 + lat));
            checkOutput("rsp_pri", sel_rsp_pri, exp_pri);
            checkOutput("rsp_qid", sel_rsp_qid, exp_qid);
            checkOutput("rsp_empty", sel_rsp_empty, exp_empty);
            checkOutput("rsp_err", sel_rsp_err, 0);
        end
        checkOutput("read_count", rd_log.size(), exp_lvls.size());
        n_chk = (rd_log.size() < exp_lvls.size()) ? rd_log.size() : exp_lvls.size();
        for (int i = 0; i < n_chk; i++) begin
            checkOutput("read_order", rd_log[i], exp_lvls[i]);
        end
        if (hold > 0) begin
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!sel_rsp_valid || sel_req_ready || sel_rsp_pri != 3'(exp_pri) ||
                    sel_rsp_qid != Q'(exp_qid) || sel_rsp_empty != 1'(exp_empty)) stable = 1'b0;
            end
            checkOutput("hold_stable", stable, 1);
        end
        @(negedge clk);
        sel_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        sel_rsp_ready = 1'b0;
        checkOutput("rsp_released", sel_rsp_valid, 0);
        checkOutput("idle_ready", sel_req_ready, 1);
    endtask

    task automatic randomizeLevels(input logic [D-1:0] sch);
        for (int n = 0; n < 8; n++) begin
            mem_head[n][sch] = ($urandom_range(0, 1) == 0) ? {Q{1'b1}} : Q'($urandom_range(0, 254));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int   c0;
        bit   got, quiet;
        logic [7:0] bm;
        rst              = 1'b1;
        sel_req_valid    = 1'b0;
        sel_req_sch_id   = '0;
        sel_req_pri_bmap = 8'd0;
        sel_rsp_ready    = 1'b0;
        for (int n = 0; n < 8; n++) begin
            for (int s = 0; s < 256; s++) mem_head[n][s] = Q'($urandom);
        end
        @(posedge clk);
        #1;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Empty bitmap: no reads, immediate empty response.
        applyStimulus(8'd5, 8'h00, 1, 0);

        mem_head[2][5] = 8'h1A;
        applyStimulus(8'd5, 8'h24, 1, 0);

        mem_head[0][9] = 8'hFF;
        mem_head[7][9] = 8'h03;
        applyStimulus(8'd9, 8'h81, 1, 0);

        mem_head[1][7] = 8'hFF;
        mem_head[2][7] = 8'hFF;
        applyStimulus(8'd7, 8'h06, 2, 10);

        // Spurious level-3 acks in IDLE and while waiting on level 1.
        mem_head[1][12] = 8'h11;
        mem_head[3][12] = 8'h33;
        spur_ack = 8'h08;
        repeat (3) @(posedge clk);
        applyStimulus(8'd12, 8'h0A, 3, 0);
        spur_ack = 8'h00;

        for (int t = 0; t < 40; t++) begin
            logic [D-1:0] sch;
            sch = D'($urandom);
            randomizeLevels(sch);
            bm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(sch, bm, $urandom_range(1, 3), $urandom_range(0, 3));
        end

`ifdef TM_SCH_PRI_SEL_TIMEOUT_EN
        withhold = 1'b1;
        cur_sch  = 8'd3;
        @(negedge clk);
        sel_req_valid    = 1'b1;
        sel_req_sch_id   = 8'd3;
        sel_req_pri_bmap = 8'h10;
        @(posedge clk);
        #1;
        sel_req_valid = 1'b0;
        c0  = cyc;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            @(negedge clk);
            if (sel_rsp_valid) got = 1'b1;
        end
        checkOutput("to_seen", got, 1);
        checkOutput("to_latency", cyc - c0, 257);
        checkOutput("to_fields", {sel_rsp_err, sel_rsp_empty, sel_rsp_pri, sel_rsp_qid}, {1'b1, 1'b1, 3'd4, 8'd0});
        @(negedge clk);
        sel_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        sel_rsp_ready = 1'b0;
        checkOutput("to_released", sel_rsp_valid, 0);
        withhold = 1'b0;
`endif

        // Reset while a read is outstanding.
        withhold = 1'b1;
        cur_sch  = 8'h33;
        @(negedge clk);
        sel_req_valid    = 1'b1;
        sel_req_sch_id   = 8'h33;
        sel_req_pri_bmap = 8'h40;
        @(posedge clk);
        #1;
        sel_req_valid = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sel_rsp_valid || sel_req_ready) quiet = 1'b0;
        end
        checkOutput("wait_quiet", quiet, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("mid_reset");
        @(negedge clk);
        rst      = 1'b0;
        withhold = 1'b0;

        randomizeLevels(8'h44);
        applyStimulus(8'h44, 8'hFF, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
